// File: rtl/npc_ras_unit_pkg.sv
// Shared definitions for the next-PC unit: opcode encodings, default vectors
// and the branch-offset helper.
package npc_ras_unit_pkg;

   typedef enum logic [2:0] {
      NPC_SEQ   = 3'b000,
      NPC_J     = 3'b001,
      NPC_BGTZ  = 3'b010,
      NPC_BEQ   = 3'b011,
      NPC_JAL   = 3'b100,
      NPC_JR    = 3'b101,
      NPC_JR_RA = 3'b110,
      NPC_RSVD  = 3'b111
   } npc_op_e;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

   // Word offset to byte offset, sign-extended to 32 bits.
   function automatic logic [31:0] sext_shift(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/npc_ras_unit_ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
   parameter int unsigned RAS_DEPTH = 4,
   parameter int unsigned ADDR_W    = 32,
   localparam int unsigned PTR_W    = $clog2(RAS_DEPTH),
   localparam int unsigned CNT_W    = $clog2(RAS_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic [CNT_W-1:0]  count
);

   logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [PTR_W-1:0]  top_idx;

   // ptr_q names the next free slot, so the newest entry sits one below it.
   assign top_idx = ptr_q - PTR_W'(1);
   assign top     = mem_q[top_idx];
   assign count   = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         ptr_q   <= '0;
         count_q <= '0;
      end else if (push) begin
         mem_q[ptr_q] <= push_data;
         ptr_q        <= ptr_q + PTR_W'(1);
         if (count_q != CNT_W'(RAS_DEPTH)) begin
            count_q <= count_q + CNT_W'(1);
         end
      end else if (pop && (count_q != '0)) begin
         ptr_q   <= ptr_q - PTR_W'(1);
         count_q <= count_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/npc_ras_unit.sv
// Next-PC unit: PC/EPC registers, next-address mux, return-address stack and
// a saturating count of return mispredicts.
module npc_ras_unit
   import npc_ras_unit_pkg::*;
#(
   parameter int unsigned     ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(EXC_VEC_DEF),
   parameter int unsigned     RAS_DEPTH = 4,
   parameter int unsigned     CNT_W     = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           stall,
   input  logic [2:0]                     npc_op,
   input  logic [15:0]                    imm16,
   input  logic [25:0]                    imm26,
   input  logic [ADDR_W-1:0]              gpr_rs,
   input  logic                           cmp_eq,
   input  logic                           exc_req,
   input  logic                           eret,
   output logic [ADDR_W-1:0]              pc,
   output logic [ADDR_W-1:0]              pc_add_4,
   output logic [ADDR_W-1:0]              npc,
   output logic [ADDR_W-1:0]              epc,
   output logic                           ras_hit,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic [CNT_W-1:0]               ras_miss_cnt
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] epc_q;
   logic [CNT_W-1:0]  miss_q;
   logic [ADDR_W-1:0] sext;
   logic [ADDR_W-1:0] ras_top;
   logic              is_ret;
   logic              ras_push;
   logic              ras_pop;

   assign sext     = ADDR_W'(signed'(sext_shift(imm16)));
   assign pc_add_4 = pc_q + ADDR_W'(4);
   assign pc       = pc_q;
   assign epc      = epc_q;

   always_comb begin
      npc = pc_add_4;
      if (exc_req) begin
         npc = EXC_VEC;
      end else if (eret) begin
         npc = epc_q;
      end else begin
         case (npc_op_e'(npc_op))
            NPC_J, NPC_JAL: npc = {pc_q[ADDR_W-1:28], imm26, 2'b00};
            NPC_BGTZ:       npc = ($signed(gpr_rs) > 0) ? pc_q + sext : pc_add_4;
            NPC_BEQ:        npc = cmp_eq ? pc_add_4 + sext : pc_add_4;
            NPC_JR, NPC_JR_RA: npc = gpr_rs;
            default:        npc = pc_add_4;
         endcase
      end
   end

   // The stack only predicts; jr_ra always goes to gpr_rs regardless of hit.
   assign is_ret   = (npc_op == NPC_JR_RA);
   assign ras_hit  = is_ret && (ras_count != '0) && (ras_top == gpr_rs);
   assign ras_push = !stall && !exc_req && (npc_op == NPC_JAL);
   assign ras_pop  = !stall && !exc_req && is_ret;

   ras_stack #(
      .RAS_DEPTH (RAS_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_ras_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_add_4),
      .top       (ras_top),
      .count     (ras_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         epc_q  <= '0;
         miss_q <= '0;
      end else if (!stall) begin
         pc_q <= npc;
         if (exc_req) begin
            epc_q <= pc_q;
         end
         if (ras_pop && !ras_hit && (miss_q != '1)) begin
            miss_q <= miss_q + CNT_W'(1);
         end
      end
   end

   assign ras_miss_cnt = miss_q;

endmodule

// File: tb/tb_npc_ras_unit.sv
// Directed vector bench for npc_ras_unit, plus a small-counter instance used to
// check miss-counter saturation.
module tb_npc_ras_unit;
   import npc_ras_unit_pkg::*;

   typedef struct {
      logic        stall;
      logic [2:0]  op;
      logic [15:0] imm16;
      logic [25:0] imm26;
      logic [31:0] rs;
      logic        eq;
      logic        exc;
      logic        eret;
      logic [31:0] e_npc;
      logic        e_hit;
      logic [31:0] e_pc;
      logic [31:0] e_epc;
      logic [2:0]  e_cnt;
      logic [15:0] e_miss;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [2:0]  npc_op;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] gpr_rs;
   logic        cmp_eq;
   logic        exc_req;
   logic        eret;
   logic [31:0] pc, pc_add_4, npc, epc;
   logic        ras_hit;
   logic [2:0]  ras_count;
   logic [15:0] ras_miss_cnt;

   logic        s_rst_n;
   logic [31:0] s_pc, s_pc_add_4, s_npc, s_epc;
   logic        s_hit;
   logic [1:0]  s_count;
   logic [1:0]  s_miss;

   int n_vec  = 0;
   int n_miss = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   npc_ras_unit u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .npc_op       (npc_op),
      .imm16        (imm16),
      .imm26        (imm26),
      .gpr_rs       (gpr_rs),
      .cmp_eq       (cmp_eq),
      .exc_req      (exc_req),
      .eret         (eret),
      .pc           (pc),
      .pc_add_4     (pc_add_4),
      .npc          (npc),
      .epc          (epc),
      .ras_hit      (ras_hit),
      .ras_count    (ras_count),
      .ras_miss_cnt (ras_miss_cnt)
   );

   npc_ras_unit #(
      .RAS_DEPTH (2),
      .CNT_W     (2)
   ) u_sat (
      .clk          (clk),
      .rst_n        (s_rst_n),
      .stall        (1'b0),
      .npc_op       (3'b110),
      .imm16        (16'h0000),
      .imm26        (26'h0),
      .gpr_rs       (32'h0),
      .cmp_eq       (1'b0),
      .exc_req      (1'b0),
      .eret         (1'b0),
      .pc           (s_pc),
      .pc_add_4     (s_pc_add_4),
      .npc          (s_npc),
      .epc          (s_epc),
      .ras_hit      (s_hit),
      .ras_count    (s_count),
      .ras_miss_cnt (s_miss)
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic [2:0] op, input logic [15:0] i16,
                      input logic [25:0] i26, input logic [31:0] rs, input logic eq,
                      input logic ex, input logic er, input logic [31:0] e_npc,
                      input logic e_hit, input logic [31:0] e_pc, input logic [31:0] e_epc,
                      input logic [2:0] e_cnt, input logic [15:0] e_miss);
      vec_t v;
      v.stall = st;  v.op = op;      v.imm16 = i16;   v.imm26 = i26;
      v.rs = rs;     v.eq = eq;      v.exc = ex;      v.eret = er;
      v.e_npc = e_npc; v.e_hit = e_hit; v.e_pc = e_pc; v.e_epc = e_epc;
      v.e_cnt = e_cnt; v.e_miss = e_miss;
      vecs.push_back(v);
   endtask

   initial begin
      rst_n = 1'b0;  s_rst_n = 1'b0;
      stall = 1'b1;  npc_op = NPC_SEQ; imm16 = '0; imm26 = '0;
      gpr_rs = '0;   cmp_eq = 1'b0;    exc_req = 1'b0; eret = 1'b0;

      //  st op         imm16    imm26     rs            eq ex er  npc           hit pc            epc          cnt miss
      add(0, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 0, 0, 32'h3004,     0, 32'h3004,     32'h0,       0, 0);
      add(0, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 0, 0, 32'h3008,     0, 32'h3008,     32'h0,       0, 0);
      add(0, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 0, 0, 32'h300C,     0, 32'h300C,     32'h0,       0, 0);
      add(1, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 0, 0, 32'h3010,     0, 32'h300C,     32'h0,       0, 0);
      add(1, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 0, 0, 32'h3010,     0, 32'h300C,     32'h0,       0, 0);
      add(0, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 0, 0, 32'h3010,     0, 32'h3010,     32'h0,       0, 0);
      add(1, NPC_BGTZ,  16'h4,   26'h0,    32'hFFFFFFFF, 0, 0, 0, 32'h3014,     0, 32'h3010,     32'h0,       0, 0);
      add(1, NPC_BGTZ,  16'h4,   26'h0,    32'h5,        0, 0, 0, 32'h3020,     0, 32'h3010,     32'h0,       0, 0);
      add(1, NPC_BEQ,   16'hFFFF,26'h0,    32'h0,        1, 0, 0, 32'h3010,     0, 32'h3010,     32'h0,       0, 0);
      add(0, NPC_BEQ,   16'hFFFF,26'h0,    32'h0,        0, 0, 0, 32'h3014,     0, 32'h3014,     32'h0,       0, 0);
      add(0, NPC_BGTZ,  16'h4,   26'h0,    32'h0,        0, 0, 0, 32'h3018,     0, 32'h3018,     32'h0,       0, 0);
      add(0, NPC_JR,    16'h0,   26'h0,    32'h3000,     0, 0, 0, 32'h3000,     0, 32'h3000,     32'h0,       0, 0);
      add(0, NPC_JAL,   16'h0,   26'hC40,  32'h0,        0, 0, 0, 32'h3100,     0, 32'h3100,     32'h0,       1, 0);
      add(0, NPC_JR_RA, 16'h0,   26'h0,    32'h3004,     0, 0, 0, 32'h3004,     1, 32'h3004,     32'h0,       0, 0);
      add(0, NPC_JAL,   16'h0,   26'hC10,  32'h0,        0, 0, 0, 32'h3040,     0, 32'h3040,     32'h0,       1, 0);
      add(0, NPC_JAL,   16'h0,   26'hC20,  32'h0,        0, 0, 0, 32'h3080,     0, 32'h3080,     32'h0,       2, 0);
      add(0, NPC_JAL,   16'h0,   26'hC30,  32'h0,        0, 0, 0, 32'h30C0,     0, 32'h30C0,     32'h0,       3, 0);
      add(0, NPC_JAL,   16'h0,   26'hC40,  32'h0,        0, 0, 0, 32'h3100,     0, 32'h3100,     32'h0,       4, 0);
      add(0, NPC_JAL,   16'h0,   26'hC50,  32'h0,        0, 0, 0, 32'h3140,     0, 32'h3140,     32'h0,       4, 0);
      add(0, NPC_JR_RA, 16'h0,   26'h0,    32'h3104,     0, 0, 0, 32'h3104,     1, 32'h3104,     32'h0,       3, 0);
      add(0, NPC_JR_RA, 16'h0,   26'h0,    32'h30C4,     0, 0, 0, 32'h30C4,     1, 32'h30C4,     32'h0,       2, 0);
      add(0, NPC_JR_RA, 16'h0,   26'h0,    32'h3084,     0, 0, 0, 32'h3084,     1, 32'h3084,     32'h0,       1, 0);
      add(0, NPC_JR_RA, 16'h0,   26'h0,    32'h3044,     0, 0, 0, 32'h3044,     1, 32'h3044,     32'h0,       0, 0);
      add(0, NPC_JR_RA, 16'h0,   26'h0,    32'h3008,     0, 0, 0, 32'h3008,     0, 32'h3008,     32'h0,       0, 1);
      add(0, NPC_JAL,   16'h0,   26'hC10,  32'h0,        0, 0, 0, 32'h3040,     0, 32'h3040,     32'h0,       1, 1);
      add(1, NPC_JR_RA, 16'h0,   26'h0,    32'h300C,     0, 0, 0, 32'h300C,     1, 32'h3040,     32'h0,       1, 1);
      add(0, NPC_JR_RA, 16'h0,   26'h0,    32'h3040,     0, 0, 0, 32'h3040,     0, 32'h3040,     32'h0,       0, 2);
      add(0, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 1, 1, 32'h4180,     0, 32'h4180,     32'h3040,    0, 2);
      add(0, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 0, 1, 32'h3040,     0, 32'h3040,     32'h3040,    0, 2);
      add(0, NPC_JAL,   16'h0,   26'hC50,  32'h0,        0, 1, 0, 32'h4180,     0, 32'h4180,     32'h3040,    0, 2);
      add(0, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 0, 1, 32'h3040,     0, 32'h3040,     32'h3040,    0, 2);
      add(0, NPC_JR_RA, 16'h0,   26'h0,    32'h0,        0, 1, 0, 32'h4180,     0, 32'h4180,     32'h3040,    0, 2);
      add(0, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 0, 1, 32'h3040,     0, 32'h3040,     32'h3040,    0, 2);
      add(0, NPC_JR,    16'h0,   26'h0,    32'hFFFFFFFC, 0, 0, 0, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 32'h3040,    0, 2);
      add(1, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 1, 0, 32'h4180,     0, 32'hFFFFFFFC, 32'h3040,    0, 2);
      add(0, NPC_SEQ,   16'h0,   26'h0,    32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        32'h3040,    0, 2);
      add(0, NPC_JR,    16'h0,   26'h0,    32'hF0000010, 0, 0, 0, 32'hF0000010, 0, 32'hF0000010, 32'h3040,    0, 2);
      add(0, NPC_J,     16'h0,   26'h3FFFFFF, 32'h0,     0, 0, 0, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 32'h3040,    0, 2);
      add(0, NPC_BGTZ,  16'h2,   26'h0,    32'h1,        0, 0, 0, 32'h4,        0, 32'h4,        32'h3040,    0, 2);
      add(0, NPC_JAL,   16'h0,   26'hC00,  32'h0,        0, 0, 0, 32'h3000,     0, 32'h3000,     32'h3040,    1, 2);
      add(0, NPC_RSVD,  16'h0,   26'h0,    32'h0,        0, 0, 0, 32'h3004,     0, 32'h3004,     32'h3040,    1, 2);
      add(0, NPC_JR,    16'h0,   26'h0,    32'h8,        0, 0, 0, 32'h8,        0, 32'h8,        32'h3040,    1, 2);

      #12;
      chk("reset pc", -1, pc, 32'h3000);
      chk("reset epc", -1, epc, 32'h0);
      chk("reset ras_count", -1, 32'(ras_count), 32'h0);
      chk("reset miss_cnt", -1, 32'(ras_miss_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         stall = vecs[i].stall; npc_op = vecs[i].op; imm16 = vecs[i].imm16;
         imm26 = vecs[i].imm26; gpr_rs = vecs[i].rs; cmp_eq = vecs[i].eq;
         exc_req = vecs[i].exc; eret = vecs[i].eret;
         #1;
         n_vec++;
         chk("npc", i, npc, vecs[i].e_npc);
         chk("ras_hit", i, 32'(ras_hit), 32'(vecs[i].e_hit));
         @(posedge clk);
         #1;
         chk("pc", i, pc, vecs[i].e_pc);
         chk("pc_add_4", i, pc_add_4, vecs[i].e_pc + 32'd4);
         chk("epc", i, epc, vecs[i].e_epc);
         chk("ras_count", i, 32'(ras_count), 32'(vecs[i].e_cnt));
         chk("ras_miss_cnt", i, 32'(ras_miss_cnt), 32'(vecs[i].e_miss));
      end

      // Asynchronous reset mid-cycle while stalled, checked before the next edge.
      @(negedge clk);
      stall = 1'b1; npc_op = NPC_SEQ; exc_req = 1'b0; eret = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      chk("async pc", -2, pc, 32'h3000);
      chk("async epc", -2, epc, 32'h0);
      chk("async ras_count", -2, 32'(ras_count), 32'h0);
      chk("async miss_cnt", -2, 32'(ras_miss_cnt), 32'h0);
      chk("async npc", -2, npc, 32'h3004);
      @(negedge clk);
      rst_n = 1'b1;

      // Two-bit miss counter fed a jr_ra on an empty stack every cycle.
      s_rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      chk("sat miss after 3", -3, 32'(s_miss), 32'h3);
      chk("sat ras_hit", -3, 32'(s_hit), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      chk("sat miss after 5", -3, 32'(s_miss), 32'h3);
      chk("sat ras_count", -3, 32'(s_count), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
